// File: rtl/fcmp_pkg.sv
// fcmp_pkg: shared definitions for the pipelined FP comparator.
// Holds the compare-op encoding and the operand-width helper.
package fcmp_pkg;

    localparam logic [1:0] FCMP_FEQ  = 2'b00;
    localparam logic [1:0] FCMP_FLT  = 2'b01;
    localparam logic [1:0] FCMP_FLE  = 2'b10;
    localparam logic [1:0] FCMP_RSVD = 2'b11;

    // Operand width: sign + exponent + mantissa.
    function automatic int fcmp_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/fcmp_if.sv
// fcmp_if: request/response handshake bundle for fcmp_pipe.
// master = issuer side (drives operations, consumes results), slave = comparator.
interface fcmp_if
    import fcmp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
);
    localparam int W = fcmp_w(EXP_W, MAN_W);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [W-1:0]     x1;
    logic [W-1:0]     x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             y;
    logic             nv;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, op, x1, x2, in_tag, out_ready,
        input  in_ready, out_valid, y, nv, out_tag
    );

    modport slave (
        input  in_valid, op, x1, x2, in_tag, out_ready,
        output in_ready, out_valid, y, nv, out_tag
    );
endinterface

// File: rtl/fcmp_core.sv
// fcmp_core: combinational sign/magnitude pre-compare of two FP operands.
// Optional feature macro: FCMP_IEEE_EN adds NaN/sNaN and both-zero detection;
// without it only signs and magnitude relations are produced.
module fcmp_core
    import fcmp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [fcmp_w(EXP_W, MAN_W)-1:0] a,
    input  logic [fcmp_w(EXP_W, MAN_W)-1:0] b,
    output logic                            s1,
    output logic                            s2,
    output logic                            abs_lt,
    output logic                            abs_eq
`ifdef FCMP_IEEE_EN
    ,
    output logic                            nan,
    output logic                            snan,
    output logic                            both_zero
`endif
);
    localparam int W = fcmp_w(EXP_W, MAN_W);

    logic [W-2:0] abs1, abs2;

    assign s1     = a[W-1];
    assign s2     = b[W-1];
    assign abs1   = a[W-2:0];
    assign abs2   = b[W-2:0];
    // Magnitudes are unsigned exponent:mantissa fields, so a plain compare orders them.
    assign abs_lt = abs1 < abs2;
    assign abs_eq = abs1 == abs2;

`ifdef FCMP_IEEE_EN
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] m1, m2;
    logic             n1, n2;

    assign e1 = a[W-2:MAN_W];
    assign e2 = b[W-2:MAN_W];
    assign m1 = a[MAN_W-1:0];
    assign m2 = b[MAN_W-1:0];
    assign n1 = (&e1) & (|m1);
    assign n2 = (&e2) & (|m2);

    assign nan       = n1 | n2;
    // Signalling NaN has the quiet bit (mantissa MSB) clear.
    assign snan      = (n1 & ~m1[MAN_W-1]) | (n2 & ~m2[MAN_W-1]);
    assign both_zero = ~(|abs1) & ~(|abs2);
`endif
endmodule

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: pipelined FEQ/FLT/FLE comparator with valid/ready flow control
// and tag passthrough. STAGES selects 1 or 2 register stages.
// Optional feature macro: FCMP_IEEE_EN (NaN handling, nv flag, +0 == -0).
module fcmp_pipe
    import fcmp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic  clk,
    input  logic  rstn,
    fcmp_if.slave bus
);
    typedef struct packed {
        logic             s1;
        logic             s2;
        logic             alt;
        logic             aeq;
`ifdef FCMP_IEEE_EN
        logic             nan;
        logic             snan;
        logic             bz;
`endif
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } st1_t;

    typedef struct packed {
        logic             y;
        logic             nv;
        logic [TAG_W-1:0] tag;
    } res_t;

    // Final y/nv selection from the stage-1 compare flags.
    function automatic res_t resolve(input st1_t s);
        res_t r;
        logic lt, eq;
        lt = (s.s1 & ~s.s2) | (~s.s1 & ~s.s2 & s.alt) | (s.s1 & s.s2 & ~s.alt & ~s.aeq);
        eq = (s.s1 == s.s2) & s.aeq;
`ifdef FCMP_IEEE_EN
        if (s.bz) begin
            lt = 1'b0;
            eq = 1'b1;
        end
`endif
        r.tag = s.tag;
        r.nv  = 1'b0;
        case (s.op)
            FCMP_FEQ:  r.y = eq;
            FCMP_FLT:  r.y = lt;
            FCMP_FLE:  r.y = lt | eq;
            FCMP_RSVD: r.y = 1'b0;
        endcase
`ifdef FCMP_IEEE_EN
        if (s.nan) r.y = 1'b0;
        r.nv = (s.nan & ((s.op == FCMP_FLT) | (s.op == FCMP_FLE))) |
               (s.snan & (s.op == FCMP_FEQ));
`endif
        return r;
    endfunction

    logic c_s1, c_s2, c_alt, c_aeq;
`ifdef FCMP_IEEE_EN
    logic c_nan, c_snan, c_bz;
`endif
    logic accept;
    st1_t st1_d;

    fcmp_core #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_core (
        .a         (bus.x1),
        .b         (bus.x2),
        .s1        (c_s1),
        .s2        (c_s2),
        .abs_lt    (c_alt),
        .abs_eq    (c_aeq)
`ifdef FCMP_IEEE_EN
        ,
        .nan       (c_nan),
        .snan      (c_snan),
        .both_zero (c_bz)
`endif
    );

    assign accept = bus.in_valid & bus.in_ready;

    // Pack the incoming operation's compare flags, op and tag.
    always_comb begin
        st1_d     = '0;
        st1_d.s1  = c_s1;
        st1_d.s2  = c_s2;
        st1_d.alt = c_alt;
        st1_d.aeq = c_aeq;
`ifdef FCMP_IEEE_EN
        st1_d.nan  = c_nan;
        st1_d.snan = c_snan;
        st1_d.bz   = c_bz;
`endif
        st1_d.op  = bus.op;
        st1_d.tag = bus.in_tag;
    end

    if (STAGES == 1) begin : g_s1
        logic vld_pipe;
        res_t res_q;

        // Single stage: resolved result is the output register.
        assign bus.in_ready = ~vld_pipe | bus.out_ready;

        // Stage valid bit, refilled whenever the stage can accept.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)             vld_pipe <= 1'b0;
            else if (bus.in_ready) vld_pipe <= bus.in_valid;
        end

        // Result register loads only on a real accept so held outputs stay stable.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)       res_q <= '0;
            else if (accept) res_q <= resolve(st1_d);
        end

        assign bus.out_valid = vld_pipe;
        assign bus.y         = res_q.y;
        assign bus.nv        = res_q.nv;
        assign bus.out_tag   = res_q.tag;
    end else if (STAGES == 2) begin : g_s2
        logic [2:1] vld_pipe;
        logic       adv2;
        st1_t       st1_q;
        res_t       res_q;

        // Stage 2 accepts when empty or draining; stage 1 follows through the ready chain.
        assign adv2         = ~vld_pipe[2] | bus.out_ready;
        assign bus.in_ready = ~vld_pipe[1] | adv2;

        // Per-stage valid bits advance independently under backpressure.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vld_pipe <= '0;
            end else begin
                if (bus.in_ready) vld_pipe[1] <= bus.in_valid;
                if (adv2)         vld_pipe[2] <= vld_pipe[1];
            end
        end

        // Stage-1 flag register.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)       st1_q <= '0;
            else if (accept) st1_q <= st1_d;
        end

        // Stage-2 result register, loaded only when stage 1 hands over a valid op.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)                   res_q <= '0;
            else if (vld_pipe[1] & adv2) res_q <= resolve(st1_q);
        end

        assign bus.out_valid = vld_pipe[2];
        assign bus.y         = res_q.y;
        assign bus.nv        = res_q.nv;
        assign bus.out_tag   = res_q.tag;
    end else begin : g_bad
        $error("fcmp_pipe: STAGES must be 1 or 2");
    end
endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: scoreboard bench for fcmp_pipe. A single-precision STAGES=2
// instance and a double-precision STAGES=1 instance are driven with directed
// vectors; expected results are queued at accept and checked by monitors.
module tb_fcmp_pipe;
    import fcmp_pkg::*;

`ifdef FCMP_IEEE_EN
    localparam bit IEEE = 1'b1;
`else
    localparam bit IEEE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fcmp_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(5)) bs ();
    fcmp_if #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) bd ();

    fcmp_pipe #(.EXP_W(8),  .MAN_W(23), .STAGES(2), .TAG_W(5)) dut_s (.clk(clk), .rstn(rstn), .bus(bs));
    fcmp_pipe #(.EXP_W(11), .MAN_W(52), .STAGES(1), .TAG_W(5)) dut_d (.clk(clk), .rstn(rstn), .bus(bd));

    typedef struct {
        logic       y;
        logic       nv;
        logic [4:0] tag;
        int         due;
        bit         lat;
    } exp_t;

    exp_t qs[$];
    exp_t qd[$];
    exp_t es, ed;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   bp_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor for the single-precision instance.
    always @(negedge clk) begin
        if (rstn && bs.out_valid && bs.out_ready) begin
            if (qs.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL s_spurious: got result tag %0h, expected no result", bs.out_tag);
            end else begin
                es = qs.pop_front();
                chk("s_y",   bs.y,       es.y);
                chk("s_nv",  bs.nv,      es.nv);
                chk("s_tag", bs.out_tag, es.tag);
                if (es.lat) chk("s_latency", cyc, es.due);
            end
        end
    end

    // Monitor for the double-precision instance.
    always @(negedge clk) begin
        if (rstn && bd.out_valid && bd.out_ready) begin
            if (qd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL d_spurious: got result tag %0h, expected no result", bd.out_tag);
            end else begin
                ed = qd.pop_front();
                chk("d_y",   bd.y,       ed.y);
                chk("d_nv",  bd.nv,      ed.nv);
                chk("d_tag", bd.out_tag, ed.tag);
                if (ed.lat) chk("d_latency", cyc, ed.due);
            end
        end
    end

    // Present one op (caller at posedge+1) and queue its expected result on accept.
    task automatic send_s(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic ey, input logic env, input bit lat);
        exp_t e;
        bs.in_valid = 1'b1;
        bs.op       = op;
        bs.x1       = a;
        bs.x2       = b;
        bs.in_tag   = tag;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bs.in_ready) begin
                e.y = ey; e.nv = env; e.tag = tag; e.due = cyc + 2; e.lat = lat;
                qs.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL s_accept_timeout: tag %0h in_ready stayed 0, expected 1", tag);
        bs.in_valid = 1'b0;
    endtask

    task automatic send_d(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] tag, input logic ey, input logic env, input bit lat);
        exp_t e;
        bd.in_valid = 1'b1;
        bd.op       = op;
        bd.x1       = a;
        bd.x2       = b;
        bd.in_tag   = tag;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bd.in_ready) begin
                e.y = ey; e.nv = env; e.tag = tag; e.due = cyc + 1; e.lat = lat;
                qd.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL d_accept_timeout: tag %0h in_ready stayed 0, expected 1", tag);
        bd.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (qs.size() != 0 || qd.size() != 0); i++) @(posedge clk);
        chk("drain_s", qs.size(), 0);
        chk("drain_d", qd.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bs.in_valid = 0; bs.op = 0; bs.x1 = 0; bs.x2 = 0; bs.in_tag = 0; bs.out_ready = 1;
        bd.in_valid = 0; bd.op = 0; bd.x1 = 0; bd.x2 = 0; bd.in_tag = 0; bd.out_ready = 1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bs.out_valid, 0);
        chk("rst_y",         bs.y,         0);
        chk("rst_nv",        bs.nv,        0);
        chk("rst_out_tag",   bs.out_tag,   0);
        chk("rst_d_valid",   bd.out_valid, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  bs.in_ready,  1);
        @(posedge clk);
        #1;

        // Back-to-back FLE with latency checks.
        send_s(FCMP_FLE, 32'h3F800000, 32'h40000000, 5'd1, 1'b1, 1'b0, 1);
        send_s(FCMP_FLE, 32'h40000000, 32'h3F800000, 5'd2, 1'b0, 1'b0, 1);
        send_s(FCMP_FLE, 32'hBF800000, 32'h3F800000, 5'd3, 1'b1, 1'b0, 1);
        bs.in_valid = 0;
        drain();

        // Signed zeros, NaNs, infinities, equal values, reserved op.
        send_s(FCMP_FEQ, 32'h00000000, 32'h80000000, 5'd4,  IEEE,  1'b0,  1);
        send_s(FCMP_FLT, 32'h80000000, 32'h00000000, 5'd5,  !IEEE, 1'b0,  1);
        send_s(FCMP_FLT, 32'h7FC00000, 32'h3F800000, 5'd6,  1'b0,  IEEE,  1);
        send_s(FCMP_FEQ, 32'h7FC00000, 32'h7FC00000, 5'd7,  !IEEE, 1'b0,  1);
        send_s(FCMP_FEQ, 32'h7FA00000, 32'h3F800000, 5'd8,  1'b0,  IEEE,  1);
        send_s(FCMP_FLE, 32'h7FC00000, 32'h7FC00000, 5'd9,  !IEEE, IEEE,  1);
        send_s(FCMP_FLT, 32'hC0000000, 32'hBF800000, 5'd10, 1'b1,  1'b0,  1);
        send_s(FCMP_FLE, 32'h3F800000, 32'h3F800000, 5'd11, 1'b1,  1'b0,  1);
        send_s(FCMP_FLT, 32'h3F800000, 32'h3F800000, 5'd12, 1'b0,  1'b0,  1);
        send_s(FCMP_FLT, 32'h7F800000, 32'h3F800000, 5'd13, 1'b0,  1'b0,  1);
        send_s(FCMP_FLT, 32'h3F800000, 32'h7F800000, 5'd14, 1'b1,  1'b0,  1);
        send_s(FCMP_RSVD, 32'h3F800000, 32'h40000000, 5'h1F, 1'b0, 1'b0,  1);
        send_s(FCMP_FLE, 32'h00000000, 32'h80000000, 5'd16, IEEE,  1'b0,  1);
        send_s(FCMP_FEQ, 32'h7FA00000, 32'h7FA00000, 5'd17, !IEEE, IEEE,  1);
        bs.in_valid = 0;
        drain();

        // Backpressure: 6 ops while the consumer stalls.
        bs.out_ready = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                send_s(FCMP_FLT, 32'h3F800000, 32'h40000000, 5'd20, 1'b1, 1'b0, 0);
                send_s(FCMP_FLT, 32'h40000000, 32'h3F800000, 5'd21, 1'b0, 1'b0, 0);
                send_s(FCMP_FEQ, 32'h40000000, 32'h40000000, 5'd22, 1'b1, 1'b0, 0);
                send_s(FCMP_FLE, 32'hC0000000, 32'hBF800000, 5'd23, 1'b1, 1'b0, 0);
                send_s(FCMP_FEQ, 32'h3F800000, 32'hBF800000, 5'd24, 1'b0, 1'b0, 0);
                send_s(FCMP_FLT, 32'hBF800000, 32'hC0000000, 5'd25, 1'b0, 1'b0, 0);
                bs.in_valid = 1'b0;
                bp_done = 1'b1;
            end
        join_none
        repeat (2) @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", bs.out_valid, 1);
            chk("bp_hold_tag",   bs.out_tag,   5'd20);
            chk("bp_hold_y",     bs.y,         1);
        end
        @(negedge clk);
        chk("bp_in_ready_low", bs.in_ready, 0);
        chk("bp_accepted",     qs.size(),   2);
        @(posedge clk);
        #1;
        bs.out_ready = 1'b1;
        for (int i = 0; i < 200 && !bp_done; i++) @(posedge clk);
        chk("bp_done", bp_done, 1);
        drain();

        // Reset with two ops in flight: they must be dropped.
        bs.out_ready = 1'b0;
        send_s(FCMP_FLE, 32'h3F800000, 32'h40000000, 5'd26, 1'b1, 1'b0, 0);
        send_s(FCMP_FLE, 32'h40000000, 32'h3F800000, 5'd27, 1'b0, 1'b0, 0);
        bs.in_valid = 1'b0;
        @(negedge clk);
        chk("rst2_inflight", bs.out_valid, 1);
        rstn = 1'b0;
        #1;
        chk("rst2_out_valid", bs.out_valid, 0);
        chk("rst2_out_tag",   bs.out_tag,   0);
        qs.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bs.out_ready = 1'b1;
        send_s(FCMP_FLE, 32'h3F800000, 32'h3F800000, 5'd7, 1'b1, 1'b0, 1);
        bs.in_valid = 1'b0;
        drain();
        repeat (4) @(posedge clk);
        #1;

        // Double precision, single-stage instance.
        send_d(FCMP_FLE,  64'h3FF0000000000000, 64'h4000000000000000, 5'd1,  1'b1, 1'b0, 1);
        send_d(FCMP_FLT,  64'h4000000000000000, 64'h3FF0000000000000, 5'd2,  1'b0, 1'b0, 1);
        send_d(FCMP_FLT,  64'hBFF0000000000000, 64'h3FF0000000000000, 5'd3,  1'b1, 1'b0, 1);
        send_d(FCMP_RSVD, 64'h3FF0000000000000, 64'h4000000000000000, 5'h1F, 1'b0, 1'b0, 1);
        send_d(FCMP_FEQ,  64'h3FF0000000000000, 64'h3FF0000000000000, 5'd4,  1'b1, 1'b0, 1);
        bd.in_valid = 1'b0;
        drain();

        // Single-stage backpressure: in_ready falls after one accept.
        bd.out_ready = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                send_d(FCMP_FLT, 64'h3FF0000000000000, 64'h4000000000000000, 5'd5, 1'b1, 1'b0, 0);
                send_d(FCMP_FEQ, 64'h3FF0000000000000, 64'h4000000000000000, 5'd6, 1'b0, 1'b0, 0);
                send_d(FCMP_FLE, 64'h4000000000000000, 64'h4000000000000000, 5'd7, 1'b1, 1'b0, 0);
                bd.in_valid = 1'b0;
                bp_done = 1'b1;
            end
        join_none
        @(posedge clk);
        @(negedge clk);
        chk("d_bp_in_ready_low", bd.in_ready,  0);
        chk("d_bp_accepted",     qd.size(),    1);
        chk("d_bp_hold_tag",     bd.out_tag,   5'd5);
        @(posedge clk);
        #1;
        bd.out_ready = 1'b1;
        for (int i = 0; i < 200 && !bp_done; i++) @(posedge clk);
        chk("d_bp_done", bp_done, 1);
        drain();

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
